// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : two requester ports, shared-ALU drive/return and response bus
// Revision: 1.0
// ============================================================================
interface alu_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_src1;
   logic [DATA_W-1:0] req0_src2;
   logic [3:0]        req0_ctrl;
   logic [2:0]        req0_bonus;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_src1;
   logic [DATA_W-1:0] req1_src2;
   logic [3:0]        req1_ctrl;
   logic [2:0]        req1_bonus;

   logic [DATA_W-1:0] alu_src1;
   logic [DATA_W-1:0] alu_src2;
   logic [3:0]        alu_ctrl;
   logic [2:0]        alu_bonus;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_cout;
   logic              alu_overflow;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic              rsp_cout;
   logic              rsp_overflow;

   modport slave (
      input  req0_valid, req0_src1, req0_src2, req0_ctrl, req0_bonus,
      output req0_ready,
      input  req1_valid, req1_src1, req1_src2, req1_ctrl, req1_bonus,
      output req1_ready,
      output alu_src1, alu_src2, alu_ctrl, alu_bonus,
      input  alu_result, alu_zero, alu_cout, alu_overflow,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_src1, req0_src2, req0_ctrl, req0_bonus,
      input  req0_ready,
      output req1_valid, req1_src1, req1_src2, req1_ctrl, req1_bonus,
      input  req1_ready,
      input  alu_src1, alu_src2, alu_ctrl, alu_bonus,
      output alu_result, alu_zero, alu_cout, alu_overflow,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
      output rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin arbiter sharing one combinational ALU between two ports
// Revision: 1.0
// ============================================================================
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              grant;
   logic              grant_id;
   logic              last_q;
   logic              id_q;
   logic [DATA_W-1:0] src1_q;
   logic [DATA_W-1:0] src2_q;
   logic [3:0]        ctrl_q;
   logic [2:0]        bonus_q;
   logic              rsp_id_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic              rsp_zero_q;
   logic              rsp_cout_q;
   logic              rsp_overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant is gated by rst_n so no port sees ready while reset is held.
   always_comb begin
      state_d  = state_q;
      grant    = 1'b0;
      grant_id = 1'b0;
      case (state_q)
         IDLE: begin
            if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
               grant   = 1'b1;
               state_d = EXEC;
               if (bus.req0_valid && bus.req1_valid) begin
                  grant_id = ~last_q;
               end else begin
                  grant_id = bus.req1_valid;
               end
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q         <= 1'b1;
         id_q           <= 1'b0;
         src1_q         <= '0;
         src2_q         <= '0;
         ctrl_q         <= '0;
         bonus_q        <= '0;
         rsp_id_q       <= 1'b0;
         rsp_result_q   <= '0;
         rsp_zero_q     <= 1'b0;
         rsp_cout_q     <= 1'b0;
         rsp_overflow_q <= 1'b0;
      end else begin
         if (grant) begin
            last_q  <= grant_id;
            id_q    <= grant_id;
            src1_q  <= grant_id ? bus.req1_src1  : bus.req0_src1;
            src2_q  <= grant_id ? bus.req1_src2  : bus.req0_src2;
            ctrl_q  <= grant_id ? bus.req1_ctrl  : bus.req0_ctrl;
            bonus_q <= grant_id ? bus.req1_bonus : bus.req0_bonus;
         end
         if (state_q == EXEC) begin
            rsp_id_q       <= id_q;
            rsp_result_q   <= bus.alu_result;
            rsp_zero_q     <= bus.alu_zero;
            rsp_cout_q     <= bus.alu_cout;
            rsp_overflow_q <= bus.alu_overflow;
         end
      end
   end

   assign bus.req0_ready   = grant && !grant_id;
   assign bus.req1_ready   = grant &&  grant_id;

   assign bus.alu_src1     = src1_q;
   assign bus.alu_src2     = src2_q;
   assign bus.alu_ctrl     = ctrl_q;
   assign bus.alu_bonus    = bonus_q;

   assign bus.rsp_valid    = (state_q == RESP);
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_zero     = rsp_zero_q;
   assign bus.rsp_cout     = rsp_cout_q;
   assign bus.rsp_overflow = rsp_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : scoreboard bench with a behavioural ALU feeding the shared port
// Revision: 1.0
// ============================================================================
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter_if #(.DATA_W(32)) bus ();

   alu_arbiter #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          id;
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb[$];

   // Returns {overflow, cout, zero, result}
   function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      logic        v;
      s = '0;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b0110: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0];
            c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'b0111: r = {31'd0, ($signed(a) < $signed(b))};
         4'b1100: r = ~(a | b);
         default: r = '0;
      endcase
      return {v, c, (r == 32'd0), r};
   endfunction

   always_comb begin
      {bus.alu_overflow, bus.alu_cout, bus.alu_zero, bus.alu_result} =
         alu_model(bus.alu_src1, bus.alu_src2, bus.alu_ctrl);
   end

   task automatic push_exp(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
      logic [34:0] m;
      m = alu_model(a, b, op);
      sb.push_back('{id, m[31:0], m[32], m[33], m[34]});
   endtask

   task automatic pop_exp(output exp_t e, output bit ok);
      ok = (sb.size() > 0);
      if (ok) e = sb.pop_front();
      else    e = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
   endtask

   task automatic set_req(input bit id, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op, input logic [2:0] bn);
      if (id) begin
         bus.req1_valid = v; bus.req1_src1 = a; bus.req1_src2 = b;
         bus.req1_ctrl = op; bus.req1_bonus = bn;
      end else begin
         bus.req0_valid = v; bus.req0_src1 = a; bus.req0_src2 = b;
         bus.req0_ctrl = op; bus.req0_bonus = bn;
      end
   endtask

   task automatic wait_grant(output bit ok, output bit gid);
      ok  = 1'b0;
      gid = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.req0_ready || bus.req1_ready) begin
            ok  = 1'b1;
            gid = bus.req1_ready;
         end else begin
            @(negedge clk); #1;
         end
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.rsp_valid) ok = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
   endtask

   // Issues one request, records its expectation, and returns once rsp_valid is seen.
   task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, output bit okg, output bit gid, output bit okr);
      @(negedge clk);
      set_req(id, 1'b1, a, b, op, 3'd0);
      #1;
      wait_grant(okg, gid);
      if (okg) push_exp(gid, a, b, op);
      @(negedge clk);
      if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
      #1;
      wait_rsp(okr);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
      set_req(1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 4'b0010, 3'd7);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
         failures++;
         $display("FAIL reset_handshake got=%b exp=000",
                  {bus.rsp_valid, bus.req0_ready, bus.req1_ready});
      end
      checks++;
      if ({bus.alu_src1, bus.alu_src2, bus.alu_ctrl, bus.alu_bonus} !== 71'd0) begin
         failures++;
         $display("FAIL reset_alu_outputs got=%h exp=0",
                  {bus.alu_src1, bus.alu_src2, bus.alu_ctrl, bus.alu_bonus});
      end
      checks++;
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow} !== 36'd0) begin
         failures++;
         $display("FAIL reset_rsp_regs got=%h exp=0",
                  {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow});
      end
      @(negedge clk);
      bus.req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit   okg, gid, okr, okp;
      exp_t e;
      @(negedge clk);
      set_req(1'b0, 1'b1, 32'd5, 32'd3, 4'b0010, 3'b101);
      #1;
      wait_grant(okg, gid);
      checks++;
      if (!okg || gid !== 1'b0 || bus.req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_grant got ok=%0d id=%0d exp ok=1 id=0", okg, gid);
      end
      if (okg) push_exp(gid, 32'd5, 32'd3, 4'b0010);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.req0_ready, bus.alu_src1, bus.alu_src2, bus.alu_ctrl, bus.alu_bonus}
          !== {1'b0, 1'b0, 32'd5, 32'd3, 4'b0010, 3'b101}) begin
         failures++;
         $display("FAIL single_exec got valid=%b src1=%0d src2=%0d ctrl=%b bonus=%b exp 0/5/3/0010/101",
                  bus.rsp_valid, bus.alu_src1, bus.alu_src2, bus.alu_ctrl, bus.alu_bonus);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL single_latency got rsp_valid=%b exp=1", bus.rsp_valid);
      end
      pop_exp(e, okp);
      checks++;
      if (!okp || {bus.rsp_id, bus.rsp_result, bus.rsp_zero} !== {e.id, e.res, e.z}
          || bus.rsp_result !== 32'd8) begin
         failures++;
         $display("FAIL single_rsp got id=%0d res=%0d z=%b exp id=0 res=8 z=0",
                  bus.rsp_id, bus.rsp_result, bus.rsp_zero);
      end
      okr = 1'b1;
   endtask

   task automatic test_contention();
      bit   okg, gid, okr, okp;
      exp_t e;
      int   last_cyc;
      int   n0, n1;
      apply_reset();
      bus.rsp_ready = 1'b1;
      n0 = 0;
      n1 = 0;
      last_cyc = 0;
      set_req(1'b0, 1'b1, 32'd100, 32'd7, 4'b0010, 3'd1);
      set_req(1'b1, 1'b1, 32'd50, 32'd20, 4'b0110, 3'd2);
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(okg, gid);
         checks++;
         if (!okg || gid !== k[0]) begin
            failures++;
            $display("FAIL contention_order[%0d] got ok=%0d id=%0d exp id=%0d", k, okg, gid, k[0]);
         end
         if (k > 0) begin
            checks++;
            if (cyc - last_cyc != 3) begin
               failures++;
               $display("FAIL contention_interval[%0d] got=%0d exp=3", k, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         if (gid) push_exp(1'b1, bus.req1_src1, bus.req1_src2, bus.req1_ctrl);
         else     push_exp(1'b0, bus.req0_src1, bus.req0_src2, bus.req0_ctrl);
         @(negedge clk);
         if (gid) begin
            n1++;
            set_req(1'b1, 1'b1, 32'd50 + n1, 32'd20 + 3 * n1, 4'b0110, 3'd2);
         end else begin
            n0++;
            set_req(1'b0, 1'b1, 32'd100 + 5 * n0, 32'd7 + n0, 4'b0010, 3'd1);
         end
         #1;
         wait_rsp(okr);
         pop_exp(e, okp);
         checks++;
         if (!okr || !okp || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0
             || {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow}
                !== {e.id, e.res, e.z, e.c, e.v}) begin
            failures++;
            $display("FAIL contention_rsp[%0d] got id=%0d res=%h exp id=%0d res=%h",
                     k, bus.rsp_id, bus.rsp_result, e.id, e.res);
         end
         @(negedge clk); #1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      bit          okg, gid, okr, okp;
      exp_t        e;
      logic [35:0] snap;
      @(negedge clk); #1;
      bus.rsp_ready = 1'b0;
      run_op(1'b0, 32'h0000_00F0, 32'h0000_003C, 4'b0000, okg, gid, okr);
      snap = {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow};
      pop_exp(e, okp);
      checks++;
      if (!okg || !okr || !okp || snap !== {e.id, e.res, e.z, e.c, e.v}) begin
         failures++;
         $display("FAIL bp_rsp got=%h exp=%h", snap, {e.id, e.res, e.z, e.c, e.v});
      end
      set_req(1'b1, 1'b1, 32'd9, 32'd4, 4'b0001, 3'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b100
             || {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow} !== snap) begin
            failures++;
            $display("FAIL bp_hold[%0d] got valid=%b r0=%b r1=%b rsp=%h exp 1/0/0 rsp=%h", i,
                     bus.rsp_valid, bus.req0_ready, bus.req1_ready,
                     {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow}, snap);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got valid=%b r1=%b exp valid=0 r1=1", bus.rsp_valid, bus.req1_ready);
      end
      if (bus.req1_ready) push_exp(1'b1, 32'd9, 32'd4, 4'b0001);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      #1;
      wait_rsp(okr);
      pop_exp(e, okp);
      checks++;
      if (!okr || !okp || {bus.rsp_id, bus.rsp_result} !== {e.id, e.res}) begin
         failures++;
         $display("FAIL bp_late_rsp got id=%0d res=%0d exp id=%0d res=%0d",
                  bus.rsp_id, bus.rsp_result, e.id, e.res);
      end
   endtask

   task automatic test_flags();
      bit   okg, gid, okr, okp;
      exp_t e;
      run_op(1'b1, 32'd3, 32'd3, 4'b0110, okg, gid, okr);
      pop_exp(e, okp);
      checks++;
      if (!okg || !okr || !okp || gid !== 1'b1
          || {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow}
             !== {e.id, e.res, e.z, e.c, e.v}
          || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) begin
         failures++;
         $display("FAIL flags_zero got id=%0d res=%h z=%b exp id=1 res=0 z=1",
                  bus.rsp_id, bus.rsp_result, bus.rsp_zero);
      end
      run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0010, okg, gid, okr);
      pop_exp(e, okp);
      checks++;
      if (!okg || !okr || !okp || gid !== 1'b0
          || {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow}
             !== {e.id, e.res, e.z, e.c, e.v}
          || bus.rsp_result !== 32'h8000_0000 || bus.rsp_overflow !== 1'b1) begin
         failures++;
         $display("FAIL flags_overflow got res=%h ovf=%b exp res=80000000 ovf=1",
                  bus.rsp_result, bus.rsp_overflow);
      end
   endtask

   task automatic test_reset_mid_op();
      bit   okg, gid, okr, okp;
      exp_t e;
      @(negedge clk);
      set_req(1'b0, 1'b1, 32'd11, 32'd22, 4'b0010, 3'd3);
      #1;
      wait_grant(okg, gid);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      set_req(1'b1, 1'b1, 32'd12, 32'd3, 4'b0001, 3'd4);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000
          || {bus.alu_src1, bus.alu_src2, bus.alu_ctrl, bus.alu_bonus} !== 71'd0) begin
         failures++;
         $display("FAIL midreset_clear got valid=%b src1=%0d ctrl=%b exp all 0",
                  bus.rsp_valid, bus.alu_src1, bus.alu_ctrl);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'd0) begin
            failures++;
            $display("FAIL midreset_hold[%0d] got valid=%b res=%0d exp 0/0", i,
                     bus.rsp_valid, bus.rsp_result);
         end
      end
      rst_n = 1'b1;
      #1;
      wait_grant(okg, gid);
      checks++;
      if (!okg || gid !== 1'b1) begin
         failures++;
         $display("FAIL midreset_first_grant got ok=%0d id=%0d exp id=1", okg, gid);
      end
      if (okg) push_exp(gid, 32'd12, 32'd3, 4'b0001);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      #1;
      wait_rsp(okr);
      pop_exp(e, okp);
      checks++;
      if (!okr || !okp || {bus.rsp_id, bus.rsp_result} !== {e.id, e.res} || bus.rsp_result !== 32'd15) begin
         failures++;
         $display("FAIL midreset_rsp got id=%0d res=%0d exp id=1 res=15", bus.rsp_id, bus.rsp_result);
      end
   endtask

   task automatic test_operand_hold();
      bit   okg, gid, okr, okp;
      exp_t e;
      @(negedge clk);
      set_req(1'b0, 1'b1, 32'd20, 32'd22, 4'b0010, 3'd0);
      #1;
      wait_grant(okg, gid);
      if (okg) push_exp(gid, 32'd20, 32'd22, 4'b0010);
      @(negedge clk);
      set_req(1'b0, 1'b0, 32'd1000, 32'd2000, 4'b0110, 3'd6);
      #1;
      checks++;
      if (!okg || bus.alu_src1 !== 32'd20 || bus.alu_src2 !== 32'd22) begin
         failures++;
         $display("FAIL hold_alu_src got src1=%0d src2=%0d exp 20/22", bus.alu_src1, bus.alu_src2);
      end
      wait_rsp(okr);
      pop_exp(e, okp);
      checks++;
      if (!okr || !okp || {bus.rsp_id, bus.rsp_result} !== {e.id, e.res} || bus.rsp_result !== 32'd42) begin
         failures++;
         $display("FAIL hold_rsp got res=%0d exp res=42", bus.rsp_result);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_flags();
      test_reset_mid_op();
      test_operand_hold();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
